// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave controller.
// The 2-bit state codes are also decoded by the display block.
package microwave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } mw_state_e;

  localparam logic BTN_IDLE_LEVEL  = 1'b1;
  localparam logic DOOR_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser plus a previous-value flop, used for buttons and the door switch.
// level_o is the synchronised input; fall_o is a one-cycle high-to-low event.
module button_sync #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= IDLE_LEVEL;
      sync_q <= IDLE_LEVEL;
      prev_q <= IDLE_LEVEL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/magnetron_control.sv
// Cooking-cycle controller: IDLE/COOK/PAUSE/DONE FSM driving the timer enable,
// the one-cycle timer clear pulse and a bounded end-of-cycle beep.
module magnetron_control
  import microwave_pkg::*;
#(
  parameter int unsigned BEEP_CYCLES = 20
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       mag_on,
  output logic       timer_clearn,
  output logic       beep,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = $clog2(BEEP_CYCLES + 1);

  logic start_level_unused;
  logic stop_level_unused;
  logic door_fall_unused;
  logic start_fall;
  logic stop_fall;
  logic door_s;

  button_sync #(.IDLE_LEVEL(BTN_IDLE_LEVEL)) u_start_sync (
    .clk_i   (clock),
    .rst_ni  (clearn),
    .async_i (startn),
    .level_o (start_level_unused),
    .fall_o  (start_fall)
  );

  button_sync #(.IDLE_LEVEL(BTN_IDLE_LEVEL)) u_stop_sync (
    .clk_i   (clock),
    .rst_ni  (clearn),
    .async_i (stopn),
    .level_o (stop_level_unused),
    .fall_o  (stop_fall)
  );

  button_sync #(.IDLE_LEVEL(DOOR_IDLE_LEVEL)) u_door_sync (
    .clk_i   (clock),
    .rst_ni  (clearn),
    .async_i (door_closed),
    .level_o (door_s),
    .fall_o  (door_fall_unused)
  );

  mw_state_e        state_q;
  logic             mag_on_q;
  logic             timer_clearn_q;
  logic             beep_q;
  logic [CNT_W-1:0] beep_cnt_q;
  logic [CNT_W-1:0] beep_cnt_d;

  assign beep_cnt_d = beep_cnt_q - CNT_W'(1);

  // Outputs are registered alongside the state, so each branch sets them for the state it enters.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q        <= ST_IDLE;
      mag_on_q       <= 1'b0;
      timer_clearn_q <= 1'b1;
      beep_q         <= 1'b0;
      beep_cnt_q     <= '0;
    end else begin
      timer_clearn_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (stop_fall) begin
            timer_clearn_q <= 1'b0;
          end else if (start_fall && door_s && !timer_zero) begin
            state_q  <= ST_COOK;
            mag_on_q <= 1'b1;
          end
        end
        ST_COOK: begin
          if (timer_zero) begin
            state_q    <= ST_DONE;
            mag_on_q   <= 1'b0;
            beep_q     <= 1'b1;
            beep_cnt_q <= CNT_W'(BEEP_CYCLES);
          end else if (!door_s || stop_fall) begin
            state_q  <= ST_PAUSE;
            mag_on_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (stop_fall) begin
            state_q        <= ST_IDLE;
            timer_clearn_q <= 1'b0;
          end else if (start_fall && door_s) begin
            state_q  <= ST_COOK;
            mag_on_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (stop_fall || beep_cnt_d == '0) begin
            state_q    <= ST_IDLE;
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
          end else begin
            beep_cnt_q <= beep_cnt_d;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          mag_on_q <= 1'b0;
          beep_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mag_on       = mag_on_q;
  assign timer_clearn = timer_clearn_q;
  assign beep         = beep_q;
  assign state        = state_q;

endmodule

// File: tb/tb_magnetron_control.sv
// Directed bench for magnetron_control with hand-computed expectations.
module tb_magnetron_control;

  logic       clock = 1'b0;
  logic       clearn = 1'b0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       door_closed = 1'b0;
  logic       timer_zero = 1'b0;
  logic       mag_on;
  logic       timer_clearn;
  logic       beep;
  logic [1:0] state;

  int checks = 0;
  int fails = 0;

  magnetron_control #(.BEEP_CYCLES(20)) dut (
    .clock        (clock),
    .clearn       (clearn),
    .startn       (startn),
    .stopn        (stopn),
    .door_closed  (door_closed),
    .timer_zero   (timer_zero),
    .mag_on       (mag_on),
    .timer_clearn (timer_clearn),
    .beep         (beep),
    .state        (state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Press start for 3 edges (event acted on at the 3rd), release and let the sync settle.
  task automatic press_start();
    startn = 1'b0;
    ticks(3);
    startn = 1'b1;
    ticks(2);
  endtask

  task automatic press_stop();
    stopn = 1'b0;
    ticks(3);
    stopn = 1'b1;
    ticks(2);
  endtask

  task automatic test_reset();
    clearn = 1'b0;
    ticks(2);
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (mag_on !== 1'b0) begin fails++; $display("FAIL reset_mag_on: got %b want 0", mag_on); end
    checks++; if (timer_clearn !== 1'b1) begin fails++; $display("FAIL reset_timer_clearn: got %b want 1", timer_clearn); end
    checks++; if (beep !== 1'b0) begin fails++; $display("FAIL reset_beep: got %b want 0", beep); end
    clearn = 1'b1;
    door_closed = 1'b1;
    ticks(3);
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL post_reset_idle: got %0d want 0", state); end
  endtask

  task automatic test_start_cook();
    startn = 1'b0;
    tick();
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL start_edge1_state: got %0d want 0", state); end
    tick();
    checks++; if (mag_on !== 1'b0) begin fails++; $display("FAIL start_edge2_mag_on: got %b want 0", mag_on); end
    tick();
    checks++; if (mag_on !== 1'b1) begin fails++; $display("FAIL start_edge3_mag_on: got %b want 1", mag_on); end
    checks++; if (state !== 2'd1) begin fails++; $display("FAIL start_edge3_state: got %0d want 1", state); end
    startn = 1'b1;
    ticks(4);
    checks++; if (state !== 2'd1 || mag_on !== 1'b1) begin fails++; $display("FAIL start_hold_stays_cook: got state %0d mag %b want 1 1", state, mag_on); end
  endtask

  task automatic test_done_beep();
    int n;
    timer_zero = 1'b1;
    tick();
    timer_zero = 1'b0;
    checks++; if (state !== 2'd3) begin fails++; $display("FAIL done_state: got %0d want 3", state); end
    checks++; if (mag_on !== 1'b0) begin fails++; $display("FAIL done_mag_on: got %b want 0", mag_on); end
    checks++; if (beep !== 1'b1) begin fails++; $display("FAIL done_beep_start: got %b want 1", beep); end
    n = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (beep !== 1'b1) break;
      n++;
    end
    checks++; if (n != 20) begin fails++; $display("FAIL beep_length: got %0d want 20", n); end
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL done_to_idle: got %0d want 0", state); end
    checks++; if (timer_clearn !== 1'b1) begin fails++; $display("FAIL done_no_clear: got %b want 1", timer_clearn); end
  endtask

  task automatic test_door_pause();
    press_start();
    checks++; if (state !== 2'd1) begin fails++; $display("FAIL pause_setup_cook: got %0d want 1", state); end
    door_closed = 1'b0;
    ticks(2);
    checks++; if (mag_on !== 1'b1) begin fails++; $display("FAIL door_open_edge2_mag: got %b want 1", mag_on); end
    tick();
    checks++; if (state !== 2'd2 || mag_on !== 1'b0) begin fails++; $display("FAIL door_open_pause: got state %0d mag %b want 2 0", state, mag_on); end
    press_start();
    checks++; if (state !== 2'd2) begin fails++; $display("FAIL start_door_open_ignored: got %0d want 2", state); end
    door_closed = 1'b1;
    ticks(3);
    press_start();
    checks++; if (state !== 2'd1 || mag_on !== 1'b1) begin fails++; $display("FAIL resume_cook: got state %0d mag %b want 1 1", state, mag_on); end
  endtask

  task automatic test_stop_clear();
    press_stop();
    checks++; if (state !== 2'd2) begin fails++; $display("FAIL stop_cook_pause: got %0d want 2", state); end
    for (int k = 0; k < 2; k++) begin
      stopn = 1'b0;
      ticks(2);
      checks++; if (timer_clearn !== 1'b1) begin fails++; $display("FAIL stop%0d_clear_early: got %b want 1", k, timer_clearn); end
      tick();
      checks++; if (state !== 2'd0) begin fails++; $display("FAIL stop%0d_idle: got %0d want 0", k, state); end
      checks++; if (timer_clearn !== 1'b0) begin fails++; $display("FAIL stop%0d_clear_pulse: got %b want 0", k, timer_clearn); end
      tick();
      checks++; if (timer_clearn !== 1'b1) begin fails++; $display("FAIL stop%0d_clear_one_cycle: got %b want 1", k, timer_clearn); end
      stopn = 1'b1;
      ticks(2);
    end
  endtask

  task automatic test_simultaneous();
    startn = 1'b0;
    stopn = 1'b0;
    ticks(3);
    checks++; if (state !== 2'd0 || timer_clearn !== 1'b0) begin fails++; $display("FAIL simul_idle: got state %0d clr %b want 0 0", state, timer_clearn); end
    tick();
    checks++; if (timer_clearn !== 1'b1) begin fails++; $display("FAIL simul_idle_pulse_end: got %b want 1", timer_clearn); end
    startn = 1'b1;
    stopn = 1'b1;
    ticks(2);
    press_start();
    startn = 1'b0;
    stopn = 1'b0;
    ticks(3);
    checks++; if (state !== 2'd2 || timer_clearn !== 1'b1) begin fails++; $display("FAIL simul_cook_pause: got state %0d clr %b want 2 1", state, timer_clearn); end
    startn = 1'b1;
    stopn = 1'b1;
    ticks(2);
    press_stop();
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL simul_back_idle: got %0d want 0", state); end
  endtask

  task automatic test_done_stop();
    press_start();
    timer_zero = 1'b1;
    tick();
    timer_zero = 1'b0;
    ticks(2);
    stopn = 1'b0;
    ticks(2);
    checks++; if (state !== 2'd3 || beep !== 1'b1) begin fails++; $display("FAIL done_stop_before: got state %0d beep %b want 3 1", state, beep); end
    tick();
    checks++; if (state !== 2'd0 || beep !== 1'b0) begin fails++; $display("FAIL done_stop_cut: got state %0d beep %b want 0 0", state, beep); end
    stopn = 1'b1;
    ticks(2);
  endtask

  task automatic test_async_reset();
    press_start();
    checks++; if (state !== 2'd1) begin fails++; $display("FAIL areset_setup_cook: got %0d want 1", state); end
    #2;
    clearn = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || mag_on !== 1'b0) begin fails++; $display("FAIL areset_cook: got state %0d mag %b want 0 0", state, mag_on); end
    checks++; if (timer_clearn !== 1'b1) begin fails++; $display("FAIL areset_no_clear: got %b want 1", timer_clearn); end
    tick();
    clearn = 1'b1;
    ticks(3);
    press_start();
    timer_zero = 1'b1;
    tick();
    timer_zero = 1'b0;
    ticks(3);
    checks++; if (beep !== 1'b1) begin fails++; $display("FAIL areset_setup_done: got %b want 1", beep); end
    #3;
    clearn = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || beep !== 1'b0 || mag_on !== 1'b0) begin fails++; $display("FAIL areset_done: got state %0d beep %b mag %b want 0 0 0", state, beep, mag_on); end
    tick();
    clearn = 1'b1;
    ticks(3);
  endtask

  initial begin
    test_reset();
    test_start_cook();
    test_done_beep();
    test_door_pause();
    test_stop_clear();
    test_simultaneous();
    test_done_stop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
